polyphase_mac_seq: RTL

POLYPHASE_MAC_SEQ -- requirements
Module: polyphase_mac_seq

---
 rtl/polyphase_mac_seq_if.sv | 31 +++
 rtl/polyphase_mac_seq.sv | 117 +++++++++++
 2 files changed

// File: rtl/polyphase_mac_seq_if.sv
// Handshake bundle between the polyphase sample front-end and the shared-MAC
// sequencer. Master drives the sample strobes, slave returns the MAC controls.
interface polyphase_mac_seq_if #(
   parameter int DECIM = 3,
   parameter int NTAPS = 4
);
   localparam int PW = $clog2(DECIM);
   localparam int TW = $clog2(NTAPS);

   logic          enable;
   logic          in_valid;
   logic          clr_ovr;
   logic [PW-1:0] phase;
   logic          frame_stb;
   logic [TW-1:0] tap_sel;
   logic          mac_clr;
   logic          mac_en;
   logic          out_valid;
   logic          busy;
   logic          overrun;

   modport master (
      output enable, in_valid, clr_ovr,
      input  phase, frame_stb, tap_sel, mac_clr, mac_en, out_valid, busy, overrun
   );

   modport slave (
      input  enable, in_valid, clr_ovr,
      output phase, frame_stb, tap_sel, mac_clr, mac_en, out_valid, busy, overrun
   );
endinterface

// File: rtl/polyphase_mac_seq.sv
// Polyphase decimator sequencer: counts DECIM samples per frame, then steps a
// shared MAC through NTAPS taps and flags frames that arrive while it is busy.
module polyphase_mac_seq #(
   parameter int DECIM = 3,
   parameter int NTAPS = 4
) (
   input  logic                clk,
   input  logic                reset,
   polyphase_mac_seq_if.slave  bus
);
   localparam int PW = $clog2(DECIM);
   localparam int TW = $clog2(NTAPS);
   localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
   localparam logic [TW-1:0] TAP_LAST   = TW'(NTAPS - 1);

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   logic [PW-1:0] phase_q;
   logic          frame_q;
   state_t        state_q, state_d;
   logic [TW-1:0] tap_q, tap_d;
   logic          mac_clr_q, mac_en_q, out_valid_q, busy_q, overrun_q;
   logic          mac_clr_d, mac_en_d, out_valid_d, busy_d, overrun_d;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q <= '0;
         frame_q <= 1'b0;
      end else begin
         frame_q <= bus.enable && bus.in_valid && (phase_q == PHASE_LAST);
         if (!bus.enable)
            phase_q <= '0;
         else if (bus.in_valid)
            phase_q <= (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         tap_q   <= '0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
      end
   end

   // NOTE: defaults first so every path assigns every output; no latches.
   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      unique case (state_q)
         IDLE: begin
            if (frame_q) begin
               state_d = MAC;
               tap_d   = '0;
            end
         end
         MAC: begin
            if (tap_q == TAP_LAST)
               state_d = DONE;
            else
               tap_d = tap_q + TW'(1);
         end
         DONE: begin
            if (frame_q) begin
               state_d = MAC;
               tap_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they line up
   // with the state they describe without a decode glitch on the ports.
   always_comb begin
      mac_en_d    = (state_d == MAC);
      mac_clr_d   = (state_d == MAC) && (state_q != MAC);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
      overrun_d   = overrun_q;
      if (frame_q && (state_q == MAC))
         overrun_d = 1'b1;
      else if (bus.clr_ovr)
         overrun_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mac_clr_q   <= 1'b0;
         mac_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         mac_clr_q   <= mac_clr_d;
         mac_en_q    <= mac_en_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.phase     = phase_q;
   assign bus.frame_stb = frame_q;
   assign bus.tap_sel   = tap_q;
   assign bus.mac_clr   = mac_clr_q;
   assign bus.mac_en    = mac_en_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.overrun   = overrun_q;
endmodule
